// File: rtl/memwb_pkg.sv
// memwb_pkg -- shared definitions for the MEM/WB pipeline stage.
//   MEMWB_XLEN / MEMWB_RD_W : default data and register-index widths
//   memwb_payload_t         : MEM/WB payload at the default widths
//   REG_ZERO                : index of the hard-wired zero register
package memwb_pkg;

  localparam int MEMWB_XLEN = 32;
  localparam int MEMWB_RD_W = 5;
  localparam int REG_ZERO   = 0;

  typedef struct packed {
    logic [MEMWB_XLEN-1:0] alu;
    logic [MEMWB_XLEN-1:0] mem;
    logic [MEMWB_RD_W-1:0] rd;
    logic                  regwrite;
    logic                  memtoreg;
  } memwb_payload_t;

endpackage

// File: rtl/memwb_skid.sv
// memwb_skid -- one-entry skid buffer for memwb_pipe (used only when
// MEMWB_PIPE_SKID_EN is defined).
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   flush      : drop the held entry on the next edge
//   wr_en      : capture wr_data into the entry
//   rd_en      : the entry is being consumed this cycle
//   full       : entry holds a payload (registered)
//   rd_data    : held payload
module memwb_skid
  import memwb_pkg::*;
#(
  parameter int W = 2 * MEMWB_XLEN + MEMWB_RD_W + 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic         full,
  output logic [W-1:0] rd_data
);

  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (flush) begin
      full_d = 1'b0;
    end else begin
      if (rd_en) full_d = 1'b0;
      // A write in the same cycle as a read re-fills the entry.
      if (wr_en) begin
        full_d = 1'b1;
        data_d = wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full    = full_q;
  assign rd_data = data_q;

endmodule

// File: rtl/memwb_pipe.sv
// memwb_pipe -- MEM/WB pipeline register with valid/ready handshake and
// write-back select.
// Optional feature: define MEMWB_PIPE_SKID_EN to add a one-entry skid
// buffer (memwb_skid) so in_ready is registered and throughput is kept
// under back-pressure. Without it, in_ready = out_ready || !out_valid.
// Ports:
//   clk, rst_n         : clock, synchronous active-low reset
//   in_valid/in_ready  : upstream handshake
//   in_alu, in_mem     : ALU result, memory read data (XLEN)
//   in_rd              : destination register index (RD_W)
//   in_regwrite        : register-write control
//   in_memtoreg        : write-back select (1 = mem, 0 = alu)
//   flush              : discard all held payloads
//   out_valid/out_ready: downstream handshake
//   out_alu, out_mem, out_rd, out_memtoreg : registered payload
//   out_regwrite       : registered write enable, qualified by valid and rd != 0
//   wb_data            : write-back value selected from registered fields
module memwb_pipe
  import memwb_pkg::*;
#(
  parameter int XLEN = MEMWB_XLEN,
  parameter int RD_W = MEMWB_RD_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_alu,
  input  logic [XLEN-1:0] in_mem,
  input  logic [RD_W-1:0] in_rd,
  input  logic            in_regwrite,
  input  logic            in_memtoreg,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_alu,
  output logic [XLEN-1:0] out_mem,
  output logic [RD_W-1:0] out_rd,
  output logic            out_regwrite,
  output logic            out_memtoreg,
  output logic [XLEN-1:0] wb_data
);

  // Same layout as memwb_payload_t, but sized by this instance's parameters.
  typedef struct packed {
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] mem;
    logic [RD_W-1:0] rd;
    logic            regwrite;
    logic            memtoreg;
  } pl_t;

  localparam int PW = $bits(pl_t);

  pl_t  in_pl;
  pl_t  out_pl_q, out_pl_d;
  logic out_valid_q, out_valid_d;
  logic in_fire, out_free;
  logic src_valid;
  pl_t  src_pl;

  assign in_pl    = {in_alu, in_mem, in_rd, in_regwrite, in_memtoreg};
  assign in_fire  = in_valid && in_ready;
  // Output register can take a new payload: empty, or draining this cycle.
  assign out_free = !out_valid_q || out_ready;

`ifdef MEMWB_PIPE_SKID_EN
  logic skid_full;
  logic skid_wr, skid_rd;
  pl_t  skid_pl;

  assign in_ready = !skid_full;
  // Accepted while the output is stalled: park it in the skid entry.
  assign skid_wr  = in_fire && !out_free && !flush;
  assign skid_rd  = skid_full && out_free && !flush;

  memwb_skid #(.W(PW)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .wr_en   (skid_wr),
    .wr_data (in_pl),
    .rd_en   (skid_rd),
    .full    (skid_full),
    .rd_data (skid_pl)
  );

  // The skid entry is always older than anything on the input, and
  // in_ready is low while it is full, so the two never compete.
  assign src_valid = skid_full || in_fire;
  assign src_pl    = skid_full ? skid_pl : in_pl;
`else
  assign in_ready  = out_free;
  assign src_valid = in_fire;
  assign src_pl    = in_pl;
`endif

  always_comb begin
    out_valid_d = out_valid_q;
    out_pl_d    = out_pl_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (out_free) begin
      out_valid_d = src_valid;
      if (src_valid) out_pl_d = src_pl;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_pl_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_pl_q    <= out_pl_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_alu      = out_pl_q.alu;
  assign out_mem      = out_pl_q.mem;
  assign out_rd       = out_pl_q.rd;
  assign out_memtoreg = out_pl_q.memtoreg;
  // Writes to the zero register are never presented downstream.
  assign out_regwrite = out_pl_q.regwrite && out_valid_q &&
                        (out_pl_q.rd != RD_W'(REG_ZERO));
  assign wb_data      = out_pl_q.memtoreg ? out_pl_q.mem : out_pl_q.alu;

endmodule

// File: doc/memwb_pipe.md
MEMWB_PIPE -- requirements
Module: memwb_pipe

Interface
REQ-001 Parameter XLEN, default 32, sets the width of the ALU-result, memory-read and write-back data.
REQ-002 Parameter RD_W, default 5, sets the destination-register index width.
REQ-003 Ports (clock and reset first):
- clk  input  1  sole clock; all state updates on its rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  stage can accept the payload this cycle.
- in_alu  input  XLEN  ALU result.
- in_mem  input  XLEN  memory read data.
- in_rd  input  RD_W  destination register index.
- in_regwrite  input  1  register-write control.
- in_memtoreg  input  1  write-back select: 1 = mem, 0 = alu.
- flush  input  1  discard all held payloads.
- out_valid  output  1  output payload valid.
- out_ready  input  1  downstream accepts the payload.
- out_alu, out_mem  output  XLEN  registered data.
- out_rd  output  RD_W  registered index.
- out_regwrite  output  1  registered write enable, qualified.
- out_memtoreg  output  1  registered select.
- wb_data  output  XLEN  write-back value: out_memtoreg ? out_mem : out_alu.

Function
REQ-004 Transfer in occurs when in_valid && in_ready; transfer out occurs when out_valid && out_ready.
REQ-005 An accepted payload appears on the out_* ports on the next rising edge (latency 1 cycle) when the output register is empty or draining.
REQ-006 While out_valid=1 and out_ready=0, all out_* ports hold their values.
REQ-007 Without the skid option, in_ready = out_ready || !out_valid (combinational).
REQ-008 out_regwrite = registered regwrite && out_valid && (out_rd != 0); writes to index 0 are suppressed.
REQ-009 wb_data is combinational from registered fields only, with no input-to-output path.
REQ-010 flush=1 clears out_valid (and the skid entry) on the next edge; flush takes priority over a simultaneous transfer in, whose payload is dropped.
REQ-011 Simultaneous transfer in and transfer out with one entry held: the new payload replaces the output with no bubble.
REQ-012 Data fields of invalid entries are don't-care, except that out_regwrite stays 0.

Reset
REQ-013 When rst_n=0 at a rising edge, the following are cleared to 0: out_valid, out_alu, out_mem, out_rd, the registered regwrite, out_memtoreg, and all skid state.
REQ-014 Reset has priority over flush and over transfers; an in-flight payload is lost.
REQ-015 During reset and on the first cycle after it, in_ready=1 and out_valid=0.

Configuration
REQ-016 Macro MEMWB_PIPE_SKID_EN compiles in a one-entry skid buffer.
- Defined: in_ready is driven by a register, equal to !skid_full.
- Defined: a transfer in while the output is stalled goes to the skid entry.
- Defined: on transfer out, the skid entry moves to the output.
- Defined: throughput stays 1 per cycle under back-pressure.
- Undefined: REQ-007 applies and no skid storage exists.

Structure
REQ-017 Shared package memwb_pkg holds:
- the XLEN and RD_W defaults;
- the payload typedef memwb_payload_t {alu, mem, rd, regwrite, memtoreg};
- the constant REG_ZERO = 0.
REQ-018 Skid storage is sub-module memwb_skid, instantiated only under MEMWB_PIPE_SKID_EN; the output register and write-back mux stay in memwb_pipe.

Verification
REQ-019 Reset, then in_valid=1, alu=0x00000010, rd=3, regwrite=1, memtoreg=0, out_ready=1 -> next cycle: out_valid=1, out_rd=3, out_regwrite=1, wb_data=0x00000010.
REQ-020 Payload with memtoreg=1, mem=0xDEADBEEF, alu=0x1 -> wb_data=0xDEADBEEF.
REQ-021 Payload with rd=0, regwrite=1 -> out_valid=1, out_regwrite=0.
REQ-022 out_ready=0 for 3 cycles with out_valid=1 -> outputs stable.
- Skid disabled: in_ready=0.
- Skid enabled: one extra payload is accepted, then in_ready=0; after release, both payloads emerge in order on consecutive cycles.
REQ-023 flush=1 with in_valid=1 in the same cycle -> out_valid=0 next cycle, and the flushed payload never appears.
REQ-024 rst_n=0 while out_valid=1 and the skid is full -> next cycle: all outputs 0 and in_ready=1.
